// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_seq_unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_ASR = 4'd11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 3;
  localparam int FLAG_P = 4;
  localparam int FLAG_W = 5;

endpackage

// File: rtl/alu_shift_add_mul.sv
// N-cycle unsigned shift-add multiplier; start latches operands, done pulses
// for one cycle once the full 2N-bit product is available.
module alu_shift_add_mul #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CNT_W = $clog2(N + 1);

  logic [N-1:0]     mcand;
  logic [N-1:0]     hi;
  logic [N-1:0]     lo;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [N:0]       sum;

  // The multiplier bits leave lo from the bottom while product bits enter from the top.
  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign product = {hi, lo};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      hi   <= sum[N:1];
      lo   <= {sum[0], lo[N-1:1]};
      done <= (cnt == CNT_W'(N - 1));
      if (cnt == CNT_W'(N - 1)) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes on both sides. Defining
// ALU_MUL_EN adds the multi-cycle unsigned multiply on opcode 10.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [3:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y_out,
  output logic [N-1:0] y_hi,
  output logic         cflag,
  output logic         vflag,
  output logic         zflag,
  output logic         sflag,
  output logic         pflag,
  output logic         err
);

  state_t state;
  state_t state_nxt;

  logic              accept;
  logic              load;
  logic [N-1:0]      sc_y;
  logic              sc_c;
  logic              sc_v;
  logic              sc_err;
  logic [N-1:0]      y_nxt;
  logic [N-1:0]      hi_nxt;
  logic              mul_sel;
  logic              err_nxt;
  logic [FLAG_W-1:0] flag_nxt;
  logic [FLAG_W-1:0] flag_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

`ifdef ALU_MUL_EN
  logic           mul_done;
  logic [2*N-1:0] mul_prod;

  alu_shift_add_mul #(.N(N)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && (opcode == OP_MUL)),
    .a       (a_in),
    .b       (b_in),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_sel = (state == MUL_RUN);
  assign load    = (accept && (opcode != OP_MUL)) || (mul_sel && mul_done);
`else
  assign mul_sel = 1'b0;
  assign load    = accept;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          state_nxt = (opcode == OP_MUL) ? MUL_RUN : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
      MUL_RUN: begin
`ifdef ALU_MUL_EN
        if (mul_done) state_nxt = DONE;
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle datapath works straight off the inputs so the result is
  // captured on the accept edge itself.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    sc_y   = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        {sc_c, sc_y} = {1'b0, a_in} + {1'b0, b_in};
        sc_v = (a_in[N-1] == b_in[N-1]) && (sc_y[N-1] != a_in[N-1]);
      end
      OP_SUB: begin
        sc_y = a_in - b_in;
        sc_c = (a_in < b_in);
        sc_v = (a_in[N-1] != b_in[N-1]) && (sc_y[N-1] != a_in[N-1]);
      end
      OP_INC: begin
        sc_y = a_in + N'(1);
        sc_c = &a_in;
      end
      OP_DEC: begin
        sc_y = a_in - N'(1);
        sc_c = ~|a_in;
      end
      OP_SHR: begin
        sc_y = a_in >> 1;
        sc_c = a_in[0];
      end
      OP_SHL: begin
        sc_y = a_in << 1;
        sc_c = a_in[N-1];
      end
      OP_ASR: begin
        sc_y = {a_in[N-1], a_in[N-1:1]};
        sc_c = a_in[0];
      end
      OP_OR:   sc_y = a_in | b_in;
      OP_XOR:  sc_y = a_in ^ b_in;
      OP_AND:  sc_y = a_in & b_in;
      OP_NOT:  sc_y = ~a_in;
      default: sc_err = 1'b1;
    endcase
  end

  always_comb begin
    y_nxt   = sc_y;
    hi_nxt  = '0;
    err_nxt = sc_err;
    flag_nxt = '0;
    flag_nxt[FLAG_C] = sc_c;
    flag_nxt[FLAG_V] = sc_v;
`ifdef ALU_MUL_EN
    if (mul_sel) begin
      {hi_nxt, y_nxt}  = mul_prod;
      err_nxt          = 1'b0;
      flag_nxt[FLAG_C] = |mul_prod[2*N-1:N];
      flag_nxt[FLAG_V] = 1'b0;
    end
`endif
    flag_nxt[FLAG_Z] = ~|{hi_nxt, y_nxt};
    flag_nxt[FLAG_S] = mul_sel ? hi_nxt[N-1] : y_nxt[N-1];
    flag_nxt[FLAG_P] = ^y_nxt;
  end

  // Result registers hold after DONE; consumers qualify them with out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_out  <= '0;
      err    <= 1'b0;
      flag_q <= '0;
    end else if (load) begin
      y_out  <= y_nxt;
      err    <= err_nxt;
      flag_q <= flag_nxt;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  y_hi <= '0;
    else if (load) y_hi <= hi_nxt;
  end
`else
  assign y_hi = '0;
`endif

  assign cflag = flag_q[FLAG_C];
  assign vflag = flag_q[FLAG_V];
  assign zflag = flag_q[FLAG_Z];
  assign sflag = flag_q[FLAG_S];
  assign pflag = flag_q[FLAG_P];

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised sequential ALU with valid/ready handshakes on input and output.
- Supports single-cycle arithmetic, logic and shift ops, plus an optional multi-cycle shift-add multiply.
- Registers the result and all flags together; they are valid only while out_valid is high.
- Sits between the operand register file and the writeback stage; either side may stall.

Parameters:
- N, 16, operand/result width; legal range 4..64.
- CNT_W, $clog2(N+1), multiply iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand/opcode request
- in_ready  output  1  block can accept a request
- a_in  input  N  operand A
- b_in  input  N  operand B
- opcode  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- y_out  output  N  result, low half for MUL
- y_hi  output  N  MUL high half; 0 for all other ops
- cflag  output  1  carry/borrow/shifted-out bit
- vflag  output  1  signed overflow
- zflag  output  1  result zero
- sflag  output  1  result sign
- pflag  output  1  XOR-reduce of y_out
- err  output  1  illegal opcode

Behaviour:
- Reset (asynchronous, active-low; clock clk): state IDLE; in_ready=1; out_valid=0; every other output 0; internal operand, counter and accumulator registers 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch a_in, b_in and opcode. MUL -> MUL_RUN; any other opcode -> DONE with the result computed in the same edge.
  - MUL_RUN: in_ready=0; one shift-add step per cycle for N cycles; counter runs 0..N-1; on count N-1 -> DONE.
  - DONE: out_valid=1; outputs held stable until out_ready. On out_ready -> IDLE.
- No bypass from DONE to a new accept: in_ready is high only in IDLE. Maximum throughput is one op per 2 cycles. in_valid outside IDLE is ignored. Inputs are sampled only at the accept edge.
- Latency, accept edge T to out_valid: T+1 for single-cycle ops; T+N+1 for MUL.
- Opcodes:
  - 0 ADD: {cflag,y}=a+b; vflag = signed overflow.
  - 1 SUB: y=a-b; cflag=borrow (a<b unsigned); vflag = signed overflow.
  - 2 INC: cflag=1 when a=all-ones (wrap to 0).
  - 3 DEC: cflag=1 when a=0 (wrap to all-ones).
  - 4 SHR logical, 11 ASR: cflag=a[0].
  - 5 SHL: cflag=a[N-1].
  - 6 OR, 7 XOR, 8 AND, 9 NOT: cflag=vflag=0.
  - 10 MUL: unsigned. {y_hi,y_out}=a*b; cflag=(y_hi!=0); vflag=0.
  - 12-15: err=1, y_out=y_hi=0, all flags 0 except zflag=1; still completes through DONE.
- vflag=0 for every op other than ADD/SUB. y_hi=0 for every op other than MUL.
- Flags: zflag=({y_hi,y_out}==0); sflag = MSB of y_hi for MUL, else y_out[N-1]; pflag=^y_out.
- err=0 for every legal opcode.
- Reset asserted mid-MUL or in DONE: immediate return to IDLE, result discarded, out_valid drops asynchronously.
- Outputs are not cleared on leaving DONE; they are don't-care while out_valid=0.

Optional Feature:
- ALU_MUL_EN defined: opcode 10 is the multiplier, and the MUL_RUN state and accumulator are present.
- ALU_MUL_EN undefined: opcode 10 is treated as illegal (err=1, single-cycle), MUL_RUN is not synthesised, and y_hi is tied to 0.

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_ADD..OP_ASR), the FSM state encoding (IDLE, MUL_RUN, DONE), and the flag bit-index constants.
- One sub-module, alu_shift_add_mul: the N-cycle unsigned shift-add multiplier, with a start/done pulse interface, parametrised on N, instantiated only under ALU_MUL_EN.

Test Plan:
- N=16, ADD a=0xFFFF b=0x0001 -> one cycle after accept: y_out=0x0000, cflag=1, zflag=1, vflag=0, pflag=0.
- SUB a=0x8000 b=0x0001 -> y_out=0x7FFF, vflag=1, cflag=0, sflag=0, pflag=1.
- MUL a=0x1234 b=0x0100 (ALU_MUL_EN) -> out_valid exactly 17 cycles after accept; y_hi=0x0012, y_out=0x3400, cflag=1; in_ready=0 throughout.
- Backpressure: ADD result with out_ready=0 for 5 cycles -> out_valid and outputs stable; a new in_valid is ignored until out_ready, then accepted in IDLE.
- Illegal opcode 0xE -> err=1, y_out=0, zflag=1, one-cycle latency. Opcode 0xA with ALU_MUL_EN undefined -> same result.
- reset_n pulsed low at cycle 8 of a MUL -> out_valid=0 and in_ready=1 immediately; the next ADD completes correctly.
